// File: rtl/ins_reg_pkg.sv
// Shared constants and types for the instruction register and its downstream decoder.
package ins_reg_pkg;

   localparam int unsigned INS_W    = 16;
   localparam int unsigned OPCODE_W = 4;
   localparam int unsigned ADDR_W   = 12;

   // Opcode field type consumed by the controller's decode logic.
   typedef logic [OPCODE_W-1:0] opcode_t;

endpackage : ins_reg_pkg

// File: rtl/ins_reg.sv
// Instruction register: captures a full instruction word on loadIR and presents it
// split into a registered opcode (MSB field) and a registered address (LSB field).
// Outputs come straight from flops, so there is no combinational path from insin/loadIR.
module ins_reg
   import ins_reg_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                loadIR,
   input  logic [INS_W-1:0]    insin,
   output logic [OPCODE_W-1:0] opcode,
   output logic [ADDR_W-1:0]   address
);

   // The two fields must tile the instruction word exactly.
   if (INS_W != OPCODE_W + ADDR_W) begin : g_width_check
      $error("ins_reg: INS_W must equal OPCODE_W + ADDR_W");
   end

   logic [OPCODE_W-1:0] opcode_d;
   logic [OPCODE_W-1:0] opcode_q;
   logic [ADDR_W-1:0]   address_d;
   logic [ADDR_W-1:0]   address_q;

   // Next-state: take both fields from insin on a load, otherwise hold.
   always_comb begin
      opcode_d  = opcode_q;
      address_d = address_q;
      if (loadIR) begin
         opcode_d  = insin[INS_W-1 -: OPCODE_W];
         address_d = insin[ADDR_W-1:0];
      end else begin
         opcode_d  = opcode_q;
         address_d = address_q;
      end
   end

   // Field registers; asynchronous reset wins over any load on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opcode_q  <= {OPCODE_W{1'b0}};
         address_q <= {ADDR_W{1'b0}};
      end else begin
         opcode_q  <= opcode_d;
         address_q <= address_d;
      end
   end

   assign opcode  = opcode_q;
   assign address = address_q;

endmodule : ins_reg

// File: tb/tb_ins_reg.sv
// Directed self-checking bench for ins_reg with hand-computed expected fields.
module tb_ins_reg;

   logic        clk;
   logic        rst;
   logic        loadIR;
   logic [15:0] insin;
   logic [3:0]  opcode;
   logic [11:0] address;

   int checks;
   int errors;

   ins_reg dut (
      .clk     (clk),
      .rst     (rst),
      .loadIR  (loadIR),
      .insin   (insin),
      .opcode  (opcode),
      .address (address)
   );

   // 10 ns clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // loadIR must never be unknown while the block is out of reset.
   always @(posedge clk) begin
      if (!rst) begin
         assert (!$isunknown(loadIR)) else begin
            errors++;
            $error("FAIL loadIR_known observed=%b required=0/1", loadIR);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [3:0] op_exp, input logic [11:0] ad_exp);
      checks++;
      assert (opcode === op_exp) else begin
         errors++;
         $error("FAIL %s opcode observed=%h required=%h", tag, opcode, op_exp);
      end
      checks++;
      assert (address === ad_exp) else begin
         errors++;
         $error("FAIL %s address observed=%h required=%h", tag, address, ad_exp);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      loadIR = 1'b0;
      insin  = 16'h0000;

      // Reset state while rst is held
      #1;
      check("reset_initial", 4'h0, 12'h000);
      tick();
      tick();
      rst = 1'b0;

      // Outputs stay zero after release until the first load
      insin = 16'hFFFF;
      tick();
      check("post_reset_hold", 4'h0, 12'h000);

      // Load 16'hB0F0; no combinational path before the edge
      insin  = 16'hB0F0;
      loadIR = 1'b1;
      #1;
      check("no_comb_path", 4'h0, 12'h000);
      tick();
      check("load_B0F0", 4'hB, 12'h0F0);

      // Hold while insin changes
      loadIR = 1'b0;
      insin  = 16'h50AA;
      tick();
      check("hold_1", 4'hB, 12'h0F0);
      tick();
      check("hold_2", 4'hB, 12'h0F0);

      // Reload twice
      loadIR = 1'b1;
      tick();
      check("reload_50AA", 4'h5, 12'h0AA);
      insin = 16'hF00F;
      tick();
      check("reload_F00F", 4'hF, 12'h00F);

      // Reset pulsed between edges with loadIR high clears outputs immediately
      insin = 16'h1234;
      #2;
      rst = 1'b1;
      #1;
      check("reset_async", 4'h0, 12'h000);

      // Reset held across an edge with a load pending: the load is discarded
      insin = 16'hABCD;
      tick();
      check("reset_dominates", 4'h0, 12'h000);
      rst   = 1'b0;
      insin = 16'h1234;
      tick();
      check("load_after_reset", 4'h1, 12'h234);

      // Back-to-back loads on consecutive edges
      insin = 16'h0001;
      tick();
      check("b2b_0001", 4'h0, 12'h001);
      insin = 16'h1002;
      tick();
      check("b2b_1002", 4'h1, 12'h002);
      insin = 16'h2003;
      tick();
      check("b2b_2003", 4'h2, 12'h003);

      // Drop the load: last word held despite new insin
      loadIR = 1'b0;
      insin  = 16'h9876;
      tick();
      check("final_hold", 4'h2, 12'h003);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_ins_reg
